// File: rtl/strassen_matrix_mult.sv
// 16x16 signed matrix multiplier using one level of Strassen decomposition.
// Operands are internal closed-form constants; the seven 8x8 M products are
// built one element per cycle, then combined into C four elements per cycle.
module strassen_matrix_mult #(
  parameter int DW = 16,
  parameter int N  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [N-1:0][N-1:0][DW-1:0] C,
  output logic                         done
);

  localparam int H  = N / 2;
  localparam int HH = H * H;
  localparam int LW = $clog2(H);
  localparam int IW = $clog2(HH);

  typedef enum logic [1:0] {S_IDLE, S_PROD, S_COMB} state_t;

  // Operand generators: A[i][j] = ((i+2j) mod 7) - 3, B[i][j] = ((3i+j) mod 5) - 2
  function automatic logic [DW-1:0] a_el(input int i, input int j);
    int v;
    v = ((i + 2 * j) % 7) - 3;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] b_el(input int i, input int j);
    int v;
    v = ((3 * i + j) % 5) - 2;
    return v[DW-1:0];
  endfunction

  // Left operand of product k at quadrant-local (r,t)
  function automatic logic [DW-1:0] lop(input int k, input int r, input int t);
    case (k)
      0:       return a_el(r, t) + a_el(r + H, t + H);          // A11+A22
      1:       return a_el(r + H, t) + a_el(r + H, t + H);      // A21+A22
      2:       return a_el(r, t);                               // A11
      3:       return a_el(r + H, t + H);                       // A22
      4:       return a_el(r, t) + a_el(r, t + H);              // A11+A12
      5:       return a_el(r + H, t) - a_el(r, t);              // A21-A11
      6:       return a_el(r, t + H) - a_el(r + H, t + H);      // A12-A22
      default: return '0;
    endcase
  endfunction

  // Right operand of product k at quadrant-local (t,c)
  function automatic logic [DW-1:0] rop(input int k, input int t, input int c);
    case (k)
      0:       return b_el(t, c) + b_el(t + H, c + H);          // B11+B22
      1:       return b_el(t, c);                               // B11
      2:       return b_el(t, c + H) - b_el(t + H, c + H);      // B12-B22
      3:       return b_el(t + H, c) - b_el(t, c);              // B21-B11
      4:       return b_el(t + H, c + H);                       // B22
      5:       return b_el(t, c) + b_el(t, c + H);              // B11+B12
      6:       return b_el(t + H, c) + b_el(t + H, c + H);      // B21+B22
      default: return '0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;
  logic [N-1:0][N-1:0][DW-1:0] c_q;
  logic [DW-1:0]   m_q [7][HH];

  logic [LW-1:0]   row, col;
  logic [DW-1:0]   dot;
  logic [DW-1:0]   c11_d, c12_d, c21_d, c22_d;

  assign row = idx_q[IW-1:LW];
  assign col = idx_q[LW-1:0];

  // One element of M_k: 8-term dot product, wrapping at DW bits
  always_comb begin
    dot = '0;
    for (int t = 0; t < H; t++)
      dot = dot + lop(int'(k_q), int'(row), t) * rop(int'(k_q), t, int'(col));
  end

  // Quadrant combination of the stored M elements at the current index
  always_comb begin
    c11_d = m_q[0][idx_q] + m_q[3][idx_q] - m_q[4][idx_q] + m_q[6][idx_q];
    c12_d = m_q[2][idx_q] + m_q[4][idx_q];
    c21_d = m_q[1][idx_q] + m_q[3][idx_q];
    c22_d = m_q[0][idx_q] - m_q[1][idx_q] + m_q[2][idx_q] + m_q[5][idx_q];
  end

  // Sequencer next state: walk 7x64 product writes, then 64 combine writes
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PROD;
        k_d     = '0;
        idx_d   = '0;
      end
      S_PROD: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(HH - 1)) begin
          if (k_q == 3'd6) begin
            state_d = S_COMB;
            k_d     = '0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      S_COMB: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(HH - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // M storage; contents are scratch, so no reset
  always_ff @(posedge clk) begin
    if (state_q == S_PROD)
      m_q[k_q][idx_q] <= dot;
  end

  // Result matrix: cleared on reset, four elements written per combine cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else if (state_q == S_COMB) begin
      c_q[{1'b0, row}][{1'b0, col}] <= c11_d;
      c_q[{1'b0, row}][{1'b1, col}] <= c12_d;
      c_q[{1'b1, row}][{1'b0, col}] <= c21_d;
      c_q[{1'b1, row}][{1'b1, col}] <= c22_d;
    end
  end

  assign C    = c_q;
  assign done = done_q;

endmodule

// File: tb/tb_strassen_matrix_mult.sv
// Bench for strassen_matrix_mult: a start-acceptance model pushes the cycle at
// which done is due into a queue; a negedge monitor pops it when done appears
// and checks the full result against a naive triple-loop product.
module tb_strassen_matrix_mult;

  logic clk = 1'b0;
  logic rst, start, done;
  logic [15:0][15:0][15:0] c;

  always #5 clk = ~clk;

  strassen_matrix_mult #(.DW(16), .N(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .C     (c),
    .done  (done)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy = 0;
  int due_q[$];
  logic [15:0] gold [16][16];

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance model: start is taken only when no run is in flight
  always @(posedge clk) begin
    if (rst) begin
      due_q.delete();
      busy = 0;
    end else if (busy == 0 && start) begin
      due_q.push_back(cyc + 513);
      busy = 512;
    end else if (busy > 0) begin
      busy = busy - 1;
    end
  end

  task automatic check_mat(input string name, input bit zero);
    int nb;
    logic [15:0] e;
    nb = 0;
    n_vec++;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        e = zero ? 16'h0 : gold[i][j];
        if (c[i][j] !== e) begin
          if (nb == 0)
            $display("FAIL %s C[%0d][%0d] got %0d expected %0d", name, i, j,
                     $signed(c[i][j]), $signed(e));
          nb++;
        end
      end
    if (nb != 0) n_bad++;
  endtask

  task automatic check_el(input string name, input int i, input int j, input logic [15:0] e);
    n_vec++;
    if (c[i][j] !== e) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, $signed(c[i][j]), $signed(e));
    end
  endtask

  // Monitor: done must appear exactly when the model says, and carry the product
  always @(negedge clk) begin
    bit exp;
    exp = (due_q.size() > 0) && (due_q[0] == cyc);
    if (done !== 1'b0 || exp) begin
      n_vec++;
      if (done !== exp) begin
        n_bad++;
        $display("FAIL done_timing cyc=%0d got done=%b expected %b", cyc, done, exp);
      end
      if (exp) void'(due_q.pop_front());
      if (done === 1'b1 && exp) check_mat("result_on_done", 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int s, a, b;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        s = 0;
        for (int t = 0; t < 16; t++) begin
          a = ((i + 2 * t) % 7) - 3;
          b = ((3 * t + j) % 5) - 2;
          s = s + a * b;
        end
        gold[i][j] = s[15:0];
      end

    // Reset, then long idle
    rst = 1'b1;
    start = 1'b0;
    tick(2);
    check_mat("reset_zero", 1'b1);
    n_vec++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done got %b expected 0", done);
    end
    rst = 1'b0;
    tick(600);
    check_mat("idle_zero", 1'b1);

    // Single run
    pulse_start();
    tick(520);
    check_mat("single_run", 1'b0);
    check_el("spot_c00", 0, 0, 16'd11);
    check_el("spot_c01", 0, 1, 16'hFFF3);

    // Starts while busy are ignored
    pulse_start();
    tick(99);
    pulse_start();
    tick(378);
    pulse_start();
    tick(40);
    check_mat("busy_start", 1'b0);

    // Reset mid-run aborts and clears C
    pulse_start();
    tick(298);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_mat("midrun_reset_zero", 1'b1);
    tick(600);
    check_mat("after_abort_zero", 1'b1);
    pulse_start();
    tick(520);
    check_mat("after_abort_run", 1'b0);

    // Back-to-back runs with start held high
    start = 1'b1;
    tick(300);
    check_mat("b2b_hold_old", 1'b0);
    tick(1300);
    start = 1'b0;
    tick(530);
    check_mat("b2b_final", 1'b0);

    // Long hold
    tick(1000);
    check_mat("hold", 1'b0);

    n_vec++;
    if (due_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_done got %0d outstanding expected 0", due_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
